// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared state encoding and sizing helpers
// for the configuration chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int word_count(
    input int len,
    input int w
  );
    return (len + w - 1) / w;
  endfunction

  function automatic int last_word_bits(
    input int len,
    input int w
  );
    return ((len % w) == 0) ? w : (len % w);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_piso.sv
// ccff_piso_shifter: parallel-in/serial-out word register, bit index,
// and (CCFF_READBACK_EN) the ccff_tail collector.
module ccff_piso_shifter
  import ccff_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WB_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] in_data,
  output logic              head,
  output logic [WB_W-1:0]   word_bit
`ifdef CCFF_READBACK_EN
  ,
  input  logic              tail,
  input  logic              last,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [WB_W-1:0]   word_bit_q, word_bit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q     <= '0;
      word_bit_q <= '0;
    end else begin
      sreg_q     <= sreg_d;
      word_bit_q <= word_bit_d;
    end
  end

  always_comb begin
    sreg_d     = sreg_q;
    word_bit_d = word_bit_q;
    if (load) begin
      sreg_d     = in_data;
      word_bit_d = '0;
    end else if (shift) begin
      sreg_d     = sreg_q >> 1;
      word_bit_d = word_bit_q + WB_W'(1);
    end
  end

  assign head     = sreg_q[0];
  assign word_bit = word_bit_q;

`ifdef CCFF_READBACK_EN
  logic [DATA_W-1:0] col_q, col_d, col_nxt;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  // Unfilled upper bits of a short final word stay zero.
  always_comb begin
    col_d      = col_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    col_nxt    = col_q | (DATA_W'(tail) << word_bit_q);
    if (load) begin
      col_d = '0;
    end else if (shift) begin
      col_d = col_nxt;
      if (last || (word_bit_q == WB_W'(DATA_W - 1))) begin
        rb_data_d  = col_nxt;
        rb_valid_d = 1'b1;
        col_d      = '0;
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`endif

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams bitstream words LSB-first into the config
// flop chain. Define CCFF_READBACK_EN to return ccff_tail as rb_data words.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CHAIN_LEN = 20,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_EN
  ,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int WB_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int N_WORDS   = word_count(CHAIN_LEN, DATA_W);
  localparam int LAST_BITS = last_word_bits(CHAIN_LEN, DATA_W);
  localparam int LAST_BASE = (N_WORDS - 1) * DATA_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              load;
  logic              head_bit;
  logic [WB_W-1:0]   word_bit;
  logic              word_last;
  logic              fin;

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign word_last = (word_bit == WB_W'(DATA_W - 1));
  // Last bit: inside the final word and at its truncated length.
  assign fin = (bit_cnt_q >= CNT_W'(LAST_BASE))
            && (word_bit == WB_W'(LAST_BITS - 1));

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    in_ready      = 1'b0;
    ccff_shift_en = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    load          = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
        end
      end
      LOAD: begin
        in_ready = !abort;
        if (abort) begin
          state_d = IDLE;
        end else if (in_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ccff_shift_en = 1'b1;
        bit_cnt_d     = bit_cnt_q + CNT_W'(1);
        if (abort) begin
          state_d = IDLE;
        end else if (fin) begin
          state_d = DONE;
        end else if (word_last) begin
          state_d = LOAD;
        end
      end
      DONE: begin
        done    = !abort;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ccff_head = ccff_shift_en & head_bit;
  end

  ccff_piso_shifter #(
    .DATA_W (DATA_W),
    .WB_W   (WB_W)
  ) u_piso (
    .clk      (prog_clk),
    .rst_n    (prog_reset),
    .load     (load),
    .shift    (ccff_shift_en),
    .in_data  (in_data),
    .head     (head_bit),
    .word_bit (word_bit)
`ifdef CCFF_READBACK_EN
    ,
    .tail     (ccff_tail),
    .last     (ccff_shift_en & fin),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
`endif
  );

`ifndef CCFF_READBACK_EN
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule
